// File: rtl/sd_card_dat_responder.sv
// Card-side DAT0 responder for the single-bit SD data path: receives write blocks
// (CRC16 check, status token, busy) and sources read blocks with CRC16.
module sd_card_dat_responder #(
    parameter int NAC         = 4,
    parameter int NWR         = 2,
    parameter int BUSY_CYCLES = 8
) (
    input  logic        sd_clock,
    input  logic        reset,
    input  logic        dat_in,
    output logic        dat_out,
    output logic        dat_oe,
    input  logic        read_req,
    input  logic        write_req,
    input  logic        multiple,
    input  logic [3:0]  blocks,
    input  logic        stop,
    input  logic [31:0] tx_data,
    output logic        tx_data_req,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        crc_error,
    output logic        busy,
    output logic        done
);
    typedef enum logic [3:0] {
        IDLE, RD_WAIT, RD_START, RD_DATA, RD_CRC, RD_END,
        WR_WAIT_START, WR_DATA, WR_CRC, WR_END, WR_GAP, WR_STATUS, WR_BUSY
    } state_t;

    localparam logic [15:0] NAC_LAST  = 16'(NAC - 1);
    localparam logic [15:0] NWR_LAST  = 16'(NWR - 1);
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  blk_q, blk_d;
    logic [3:0]  blocks_q, blocks_d;
    logic        mult_q, mult_d;
    logic [31:0] shift_q, shift_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] rx_crc_q, rx_crc_d;
    logic        err_q, err_d;
    logic [31:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        crc_error_q, crc_error_d;

    logic [3:0]  blk_inc;
    logic [3:0]  blocks_eff;
    logic        more;
    logic [4:0]  tok;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        blk_inc    = (blk_q == 4'd15) ? 4'd15 : blk_q + 4'd1;
        blocks_eff = (blocks_q == 4'd0) ? 4'd1 : blocks_q;
        more       = mult_q && (blk_inc < blocks_eff);
        tok        = err_q ? 5'b01011 : 5'b00101;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        blk_d       = blk_q;
        blocks_d    = blocks_q;
        mult_d      = mult_q;
        shift_d     = shift_q;
        crc_d       = crc_q;
        rx_crc_d    = rx_crc_q;
        err_d       = err_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        crc_error_d = 1'b0;
        dat_out     = 1'b1;
        dat_oe      = 1'b0;
        tx_data_req = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                blk_d    = '0;
                mult_d   = multiple;
                blocks_d = blocks;
                crc_d    = '0;
                if (!stop) begin
                    if (read_req) begin
                        state_d = RD_WAIT;
                    end else if (write_req) begin
                        state_d = WR_WAIT_START;
                    end
                end
            end
            RD_WAIT: begin
                dat_oe = 1'b1;
                if (cnt_q == NAC_LAST) begin
                    state_d = RD_START;
                    cnt_d   = '0;
                end
            end
            RD_START: begin
                dat_oe      = 1'b1;
                dat_out     = 1'b0;
                tx_data_req = 1'b1;
                shift_d     = tx_data;
                crc_d       = '0;
                state_d     = RD_DATA;
                cnt_d       = '0;
            end
            RD_DATA: begin
                dat_oe  = 1'b1;
                dat_out = shift_q[31];
                shift_d = {shift_q[30:0], 1'b0};
                crc_d   = crc16_step(crc_q, shift_q[31]);
                if (cnt_q == 16'd31) begin
                    state_d = RD_CRC;
                    cnt_d   = '0;
                end
            end
            RD_CRC: begin
                dat_oe  = 1'b1;
                dat_out = crc_q[15];
                crc_d   = {crc_q[14:0], 1'b0};
                if (cnt_q == 16'd15) begin
                    state_d = RD_END;
                    cnt_d   = '0;
                end
            end
            RD_END: begin
                dat_oe = 1'b1;
                blk_d  = blk_inc;
                cnt_d  = '0;
                if (more) begin
                    state_d = RD_WAIT;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_WAIT_START: begin
                crc_d = '0;
                cnt_d = '0;
                if (!dat_in) begin
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                shift_d = {shift_q[30:0], dat_in};
                crc_d   = crc16_step(crc_q, dat_in);
                if (cnt_q == 16'd31) begin
                    state_d = WR_CRC;
                    cnt_d   = '0;
                end
            end
            WR_CRC: begin
                rx_crc_d = {rx_crc_q[14:0], dat_in};
                if (cnt_q == 16'd15) begin
                    state_d = WR_END;
                    cnt_d   = '0;
                end
            end
            WR_END: begin
                // dat_in here is the end bit; a 0 end bit is reported like a CRC mismatch
                err_d       = (rx_crc_q != crc_q) || !dat_in;
                rx_data_d   = shift_q;
                rx_valid_d  = 1'b1;
                crc_error_d = (rx_crc_q != crc_q) || !dat_in;
                state_d     = WR_GAP;
                cnt_d       = '0;
            end
            WR_GAP: begin
                if (cnt_q == NWR_LAST) begin
                    state_d = WR_STATUS;
                    cnt_d   = '0;
                end
            end
            WR_STATUS: begin
                dat_oe  = 1'b1;
                dat_out = tok[3'd4 - cnt_q[2:0]];
                if (cnt_q == 16'd4) begin
                    state_d = err_q ? IDLE : WR_BUSY;
                    cnt_d   = '0;
                end
            end
            WR_BUSY: begin
                dat_oe  = 1'b1;
                dat_out = 1'b0;
                if (cnt_q == BUSY_LAST) begin
                    blk_d = blk_inc;
                    cnt_d = '0;
                    if (more) begin
                        state_d = WR_WAIT_START;
                    end else begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort discards any partial block and suppresses completion pulses
        if (stop && state_q != IDLE) begin
            state_d     = IDLE;
            cnt_d       = '0;
            rx_data_d   = rx_data_q;
            rx_valid_d  = 1'b0;
            crc_error_d = 1'b0;
            tx_data_req = 1'b0;
            done        = 1'b0;
        end
    end

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            blk_q       <= '0;
            blocks_q    <= '0;
            mult_q      <= 1'b0;
            shift_q     <= '0;
            crc_q       <= '0;
            rx_crc_q    <= '0;
            err_q       <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            crc_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            blocks_q    <= blocks_d;
            mult_q      <= mult_d;
            shift_q     <= shift_d;
            crc_q       <= crc_d;
            rx_crc_q    <= rx_crc_d;
            err_q       <= err_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            crc_error_q <= crc_error_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign crc_error = crc_error_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/sd_card_dat_responder.md
# sd_card_dat_responder

Card-side DAT0 line responder for the single-bit SD data path. It is the bus partner of the host DAT physical controller. For a write it receives data blocks, checks CRC16 and returns the CRC status token and busy signalling. For a read it sources data blocks with CRC16. It sits behind the card command logic, which issues `read_req`/`write_req`/`stop`, and in front of the card memory model, which supplies and consumes 32-bit words. It serves as the bench's card model and as synthesizable card-emulation logic.

## Interface
Clocking: one clock; reset is synchronous and active-high (`sd_clock`, `reset`).

Parameters:
- NAC, 4: cycles of idle-high drive before each read start bit (≥1).
- NWR, 2: cycles between the write end bit and the CRC status start bit (≥1).
- BUSY_CYCLES, 8: cycles DAT0 is held low after a positive CRC status (≥1).

Ports:
- sd_clock  in  1  clock; all DAT sampling and driving on its rising edge.
- reset  in  1  synchronous, active-high.
- dat_in  in  1  DAT0 as driven by host.
- dat_out  out  1  DAT0 value driven by card.
- dat_oe  out  1  card DAT0 output enable.
- read_req  in  1  one-cycle pulse: start read transfer (CMD17/18 accepted).
- write_req  in  1  one-cycle pulse: start write transfer (CMD24/25 accepted).
- multiple  in  1  multi-block transfer; sampled with the request.
- blocks  in  4  block count for multi-block; 0 treated as 1; sampled with the request.
- stop  in  1  abort (CMD12); highest priority after reset.
- tx_data  in  32  next read word; must be valid while tx_data_req=1.
- tx_data_req  out  1  one-cycle pulse: tx_data sampled at this edge.
- rx_data  out  32  last received write word; held until the next block completes.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- crc_error  out  1  one-cycle pulse with rx_valid on CRC mismatch or end bit = 0.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse on normal transfer completion.

## Operation
- Block format: start bit 0, 32 data bits MSB first, 16 CRC bits MSB first, end bit 1.
- CRC16 uses polynomial x^16+x^12+x^5+1, initial value 0, computed over the 32 data bits only.
- States: IDLE, RD_WAIT, RD_START, RD_DATA, RD_CRC, RD_END, WR_WAIT_START, WR_DATA, WR_CRC, WR_END, WR_GAP, WR_STATUS, WR_BUSY.
- IDLE:
  - Drives dat_oe=0, dat_out=1.
  - If read_req and write_req arrive together, read_req wins.
  - Latches multiple and blocks, clears the block counter.
- Read path:
  - RD_WAIT: NAC cycles, dat_oe=1, dat_out=1.
  - RD_START: 1 cycle, dat_out=0, tx_data_req=1; tx_data loads the shift register and the CRC is cleared.
  - RD_DATA: 32 cycles.
  - RD_CRC: 16 cycles.
  - RD_END: 1 cycle, dat_out=1. Block counter increments. If more blocks remain → RD_WAIT, else done=1 → IDLE.
- Write path:
  - WR_WAIT_START: dat_oe=0; waits indefinitely for dat_in=0.
  - WR_DATA: 32 cycles shifting in data.
  - WR_CRC: 16 cycles shifting in the CRC.
  - WR_END: samples the end bit.
  - One cycle after the end-bit sample: rx_data updated, rx_valid=1, and crc_error=1 if the CRC mismatched or the end bit was 0.
  - WR_GAP: NWR cycles, dat_oe=0.
  - WR_STATUS: 5 cycles, dat_oe=1. Token is 0,0,1,0,1 if good, 0,1,0,1,1 if error.
  - WR_BUSY (good blocks only): BUSY_CYCLES cycles with dat_out=0.
  - After a good block: if more blocks remain → WR_WAIT_START, else done=1 → IDLE.
  - After an error: done=0 → IDLE.
- stop in any non-IDLE state: next cycle is IDLE with dat_oe=0; no done; no rx_valid for a partial block.
- Block counter is 4 bits; "more remain" means count < max(blocks,1) and multiple=1. Counters never wrap past 15.

## Timing
- Reset values:
  - Outputs: dat_out=1, dat_oe=0, rx_data=0, and tx_data_req, rx_valid, crc_error, busy, done all 0.
  - Internal: state=IDLE, all counters and CRC cleared.
- Reset mid-transfer returns to IDLE at the next edge; DAT0 is released in that cycle.
- Read latency: request at edge k → first RD_WAIT cycle k+1 → start bit on DAT0 at k+1+NAC.
- The first data bit follows the start bit by one cycle; one block occupies 1+32+16+1 cycles after RD_WAIT.
- Write: the start bit is sampled at edge s → data bit 31 at s+1, end bit at s+49.
- The status token starts at s+50+NWR, busy follows the token immediately, and done pulses in the last WR_BUSY cycle.

## Test plan
- Single write with data 32'h00000000, CRC 16'h0000, end 1 → rx_data=0, rx_valid pulse, status 00101, 8 busy-low cycles, done once.
- The same write with CRC 16'h0001 → crc_error with rx_valid, status 01011, no busy, no done, IDLE.
- Single read with tx_data=32'hDEADBEEF → 4 ones, 0, DEADBEEF MSB first, CRC per model, 1; tx_data_req exactly once; done once.
- Multi-block read, blocks=3 → three framed blocks, each preceded by NAC ones; 3 tx_data_req pulses; 1 done.
- stop asserted at bit 10 of a read → dat_oe=0 the next cycle, busy=0, no done.
- reset asserted during WR_CRC, then a new good write → all outputs at reset values, and the second write completes normally with done.
